// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller takes the master side and the datapath the slave side.
interface multicycle_controller_if #(
    parameter int CNT_WIDTH = 32
);
    // Instruction fields and ALU status from the datapath
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7_bit5;
    logic                 Zero;

    // Datapath selects and enables
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ALUControl;
    logic [1:0]           ImmSrc;
    logic                 RegWrite;

    // Debug visibility
    logic                 illegal;
    logic [3:0]           state;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  op, funct3, funct7_bit5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, illegal, state, instr_count
    );

    modport slave (
        output op, funct3, funct7_bit5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, illegal, state, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback over one ALU and one memory port.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 retire;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7 bit 5; I-type addi never subtracts
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control = (bus.op[5] & bus.funct7_bit5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Every one of these states returns to FETCH, so leaving them retires an instruction
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign bus.PCWrite     = ~rst & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite     = ~rst & ir_write;
    assign bus.MemWrite    = ~rst & mem_write;
    assign bus.RegWrite    = ~rst & reg_write;
    assign bus.illegal     = ~rst & (state_q == S_TRAP);
    assign bus.AdrSrc      = adr_src;
    assign bus.ResultSrc   = result_src;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUControl  = alu_control;
    assign bus.ImmSrc      = imm_src;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model with randomized instruction streams plus directed corner scenarios.
module tb_multicycle_controller;

    logic clk;
    logic rst1;
    logic rst0;
    int   checks;
    int   errors;
    int   cnt1_model;
    int   cnt0_model;

    multicycle_controller_if #(.CNT_WIDTH(32)) bus1 ();
    multicycle_controller_if #(.CNT_WIDTH(4))  bus0 ();

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1), .CNT_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );
    // Narrow counter lets the wrap-around be reached in a handful of instructions
    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ctl1;
    logic [3:0]  en1;
    assign ctl1 = {bus1.PCWrite, bus1.AdrSrc, bus1.MemWrite, bus1.IRWrite, bus1.ResultSrc,
                   bus1.ALUSrcA, bus1.ALUSrcB, bus1.RegWrite, bus1.illegal};
    assign en1  = {bus1.PCWrite, bus1.IRWrite, bus1.MemWrite, bus1.RegWrite};

    // ---------------- reference model ----------------
    function automatic int path_len(input logic [6:0] op);
        case (op)
            7'd3:    return 5;
            7'd99:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int path_at(input logic [6:0] op, input int k);
        int p[5];
        case (op)
            7'd3:    p = '{0, 1, 2, 3, 4};
            7'd35:   p = '{0, 1, 2, 5, 0};
            7'd51:   p = '{0, 1, 6, 8, 0};
            7'd19:   p = '{0, 1, 7, 8, 0};
            7'd99:   p = '{0, 1, 9, 0, 0};
            default: p = '{0, 1, 10, 8, 0};
        endcase
        return p[k];
    endfunction

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, illegal}
    function automatic logic [11:0] exp_ctl(input int st, input logic z);
        logic pcw, adr, memw, irw, regw, ill;
        logic [1:0] rs, sa, sb;
        {pcw, adr, memw, irw, regw, ill} = '0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00;
        case (st)
            0:  begin pcw = 1'b1; irw = 1'b1; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; regw = 1'b1; end
            5:  begin adr = 1'b1; memw = 1'b1; end
            6:  sa = 2'b10;
            7:  begin sa = 2'b10; sb = 2'b01; end
            8:  regw = 1'b1;
            9:  begin sa = 2'b10; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            15: ill = 1'b1;
            default: ;
        endcase
        return {pcw, adr, memw, irw, rs, sa, sb, regw, ill};
    endfunction

    function automatic logic [2:0] exp_alu(input int st, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
        if (st == 9) return 3'b001;
        if (st == 6 || st == 7) begin
            case (f3)
                3'd0:    return (op == 7'd51 && f7) ? 3'b001 : 3'b000;
                3'd2:    return 3'b101;
                3'd6:    return 3'b011;
                3'd7:    return 3'b010;
                default: return 3'b000;
            endcase
        end
        return 3'b000;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            7'd35:   return 2'b01;
            7'd99:   return 2'b10;
            7'd111:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus1.op = op; bus1.funct3 = f3; bus1.funct7_bit5 = f7; bus1.Zero = z;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive1(7'd3, 3'd0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (en1 !== 4'b0000 || bus1.illegal !== 1'b0) begin
                errors++; $display("FAIL reset_enables: got en=%b illegal=%b want en=0000 illegal=0", en1, bus1.illegal);
            end
        end
        checks++;
        if (bus1.state !== 4'd0 || bus1.instr_count !== 32'd0) begin
            errors++; $display("FAIL reset_state: got state=%0d count=%0d want 0/0", bus1.state, bus1.instr_count);
        end
        tick();
        rst1 = 1'b0;
        #1;
        checks++;
        if ({bus1.IRWrite, bus1.PCWrite, bus1.ALUSrcB, bus1.ResultSrc} !== 6'b11_10_10) begin
            errors++; $display("FAIL post_reset_fetch: got IRW=%b PCW=%b SrcB=%b Res=%b want 1 1 10 10",
                               bus1.IRWrite, bus1.PCWrite, bus1.ALUSrcB, bus1.ResultSrc);
        end
        repeat (5) tick();
        cnt1_model = 1;
        checks++;
        if (bus1.instr_count !== 32'(cnt1_model)) begin
            errors++; $display("FAIL first_lw_count: got %0d want %0d", bus1.instr_count, cnt1_model);
        end
        repeat (3) tick();
        checks++;
        if (bus1.state !== 4'd3) begin
            errors++; $display("FAIL reach_memread: got %0d want 3", bus1.state);
        end
        rst1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (en1 !== 4'b0000 || bus1.illegal !== 1'b0) begin
                errors++; $display("FAIL midreset_enables: got en=%b illegal=%b want 0000/0", en1, bus1.illegal);
            end
            @(posedge clk);
        end
        #1;
        cnt1_model = 0;
        checks++;
        if (bus1.state !== 4'd0 || bus1.instr_count !== 32'(cnt1_model)) begin
            errors++; $display("FAIL midreset_state: got state=%0d count=%0d want 0/0", bus1.state, bus1.instr_count);
        end
        rst1 = 1'b0;
        #1;
        checks++;
        if ({bus1.IRWrite, bus1.PCWrite, bus1.ALUSrcB, bus1.ResultSrc} !== 6'b11_10_10) begin
            errors++; $display("FAIL release_fetch: got IRW=%b PCW=%b SrcB=%b Res=%b want 1 1 10 10",
                               bus1.IRWrite, bus1.PCWrite, bus1.ALUSrcB, bus1.ResultSrc);
        end
    endtask

    task automatic test_random_back_to_back();
        logic [6:0] ops [6];
        ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7, z;
            int         st;
            op = ops[$urandom_range(0, 5)];
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            drive1(op, f3, f7, z);
            for (int k = 0; k < path_len(op); k++) begin
                st = path_at(op, k);
                @(negedge clk);
                checks++;
                if (bus1.state !== 4'(st)) begin
                    errors++; $display("FAIL rnd_state op=%0d k=%0d: got %0d want %0d", op, k, bus1.state, st);
                end
                checks++;
                if (ctl1 !== exp_ctl(st, z)) begin
                    errors++; $display("FAIL rnd_ctl op=%0d st=%0d: got %b want %b", op, st, ctl1, exp_ctl(st, z));
                end
                checks++;
                if (bus1.ALUControl !== exp_alu(st, op, f3, f7)) begin
                    errors++; $display("FAIL rnd_alu op=%0d st=%0d f3=%0d f7=%b: got %b want %b",
                                       op, st, f3, f7, bus1.ALUControl, exp_alu(st, op, f3, f7));
                end
                checks++;
                if (bus1.ImmSrc !== exp_imm(op)) begin
                    errors++; $display("FAIL rnd_imm op=%0d: got %b want %b", op, bus1.ImmSrc, exp_imm(op));
                end
                tick();
            end
            cnt1_model++;
            checks++;
            if (bus1.state !== 4'd0 || bus1.instr_count !== 32'(cnt1_model)) begin
                errors++; $display("FAIL rnd_retire op=%0d: got state=%0d count=%0d want 0/%0d",
                                   op, bus1.state, bus1.instr_count, cnt1_model);
            end
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [4];
        logic [2:0] f3s [4];
        logic       f7s [4];
        logic [2:0] exps [4];
        ops  = '{7'd51, 7'd19, 7'd51, 7'd51};
        f3s  = '{3'd0, 3'd0, 3'd7, 3'd2};
        f7s  = '{1'b1, 1'b1, 1'b0, 1'b0};
        exps = '{3'b001, 3'b000, 3'b010, 3'b101};
        for (int c = 0; c < 4; c++) begin
            drive1(ops[c], f3s[c], f7s[c], 1'b0);
            tick(); tick();
            checks++;
            if (bus1.state !== ((ops[c] == 7'd51) ? 4'd6 : 4'd7) || bus1.ALUControl !== exps[c]) begin
                errors++; $display("FAIL alu_decode case %0d: got state=%0d alu=%b want alu=%b",
                                   c, bus1.state, bus1.ALUControl, exps[c]);
            end
            tick(); tick();
            cnt1_model++;
            checks++;
            if (bus1.state !== 4'd0 || bus1.instr_count !== 32'(cnt1_model)) begin
                errors++; $display("FAIL alu_retire case %0d: got state=%0d count=%0d want 0/%0d",
                                   c, bus1.state, bus1.instr_count, cnt1_model);
            end
        end
    endtask

    task automatic test_beq();
        for (int zi = 1; zi >= 0; zi--) begin
            drive1(7'd99, 3'd0, 1'b0, 1'(zi));
            tick(); tick();
            checks++;
            if (bus1.state !== 4'd9 || bus1.PCWrite !== 1'(zi)) begin
                errors++; $display("FAIL beq_pcwrite zero=%0d: got state=%0d PCWrite=%b want 9/%0d",
                                   zi, bus1.state, bus1.PCWrite, zi);
            end
            tick();
            cnt1_model++;
            checks++;
            if (bus1.state !== 4'd0 || bus1.instr_count !== 32'(cnt1_model)) begin
                errors++; $display("FAIL beq_latency zero=%0d: got state=%0d count=%0d want 0/%0d",
                                   zi, bus1.state, bus1.instr_count, cnt1_model);
            end
        end
    endtask

    task automatic test_jal();
        int seq [5];
        seq = '{0, 1, 10, 8, 0};
        drive1(7'd111, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus1.state !== 4'(seq[k])) begin
                errors++; $display("FAIL jal_seq k=%0d: got %0d want %0d", k, bus1.state, seq[k]);
            end
            if (seq[k] == 10) begin
                checks++;
                if (bus1.PCWrite !== 1'b1) begin
                    errors++; $display("FAIL jal_pcwrite: got %b want 1", bus1.PCWrite);
                end
            end
            if (seq[k] == 8) begin
                checks++;
                if (bus1.RegWrite !== 1'b1 || bus1.ResultSrc !== 2'b00) begin
                    errors++; $display("FAIL jal_wb: got RegWrite=%b ResultSrc=%b want 1/00", bus1.RegWrite, bus1.ResultSrc);
                end
            end
            if (k < 4) tick();
        end
        cnt1_model++;
        checks++;
        if (bus1.instr_count !== 32'(cnt1_model)) begin
            errors++; $display("FAIL jal_count: got %0d want %0d", bus1.instr_count, cnt1_model);
        end
    endtask

    task automatic test_trap();
        drive1(7'h7F, 3'd0, 1'b0, 1'b1);
        tick(); tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus1.state !== 4'd15 || bus1.illegal !== 1'b1 || en1 !== 4'b0000 ||
                bus1.instr_count !== 32'(cnt1_model)) begin
                errors++; $display("FAIL trap_hold c=%0d: got state=%0d illegal=%b en=%b count=%0d want 15/1/0000/%0d",
                                   c, bus1.state, bus1.illegal, en1, bus1.instr_count, cnt1_model);
            end
            tick();
        end
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        cnt1_model = 0;
        checks++;
        if (bus1.state !== 4'd0 || bus1.illegal !== 1'b0 || bus1.instr_count !== 32'(cnt1_model)) begin
            errors++; $display("FAIL trap_exit: got state=%0d illegal=%b count=%0d want 0/0/0",
                               bus1.state, bus1.illegal, bus1.instr_count);
        end
    endtask

    task automatic test_illegal_skip();
        bus0.op = 7'h7F; bus0.funct3 = 3'd0; bus0.funct7_bit5 = 1'b0; bus0.Zero = 1'b0;
        rst0 = 1'b0;
        #1;
        tick();
        checks++;
        if (bus0.state !== 4'd1) begin
            errors++; $display("FAIL skip_decode: got %0d want 1", bus0.state);
        end
        tick();
        checks++;
        if (bus0.state !== 4'd0 || bus0.illegal !== 1'b0 || bus0.instr_count !== 4'd0) begin
            errors++; $display("FAIL skip_return: got state=%0d illegal=%b count=%0d want 0/0/0",
                               bus0.state, bus0.illegal, bus0.instr_count);
        end
    endtask

    task automatic test_count_wrap();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        bus0.op = 7'd35;
        cnt0_model = 0;
        for (int n = 0; n < 17; n++) begin
            repeat (4) tick();
            cnt0_model = (cnt0_model + 1) % 16;
            checks++;
            if (bus0.state !== 4'd0 || bus0.instr_count !== 4'(cnt0_model)) begin
                errors++; $display("FAIL count_wrap n=%0d: got state=%0d count=%0d want 0/%0d",
                                   n, bus0.state, bus0.instr_count, cnt0_model);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt1_model = 0;
        cnt0_model = 0;
        rst1 = 1'b1;
        rst0 = 1'b1;
        drive1(7'd0, 3'd0, 1'b0, 1'b0);
        bus0.op = 7'd0; bus0.funct3 = 3'd0; bus0.funct7_bit5 = 1'b0; bus0.Zero = 1'b0;
        test_reset();
        test_random_back_to_back();
        test_alu_decode();
        test_beq();
        test_jal();
        test_trap();
        test_illegal_skip();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
